// File: rtl/auth_pkg.sv
// Shared definitions for the passcode authentication controller: FSM state
// encoding and default parameter values.
package auth_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_LOCK_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_UNSET  = 3'd0,
        ST_ARMED  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_LOCKED = 3'd4
    } auth_state_e;

endpackage

// File: rtl/auth_cmp.sv
// Combinational equality of two words, built as an AND-reduction of a
// bitwise XNOR so every bit position contributes to the result.
module auth_cmp #(
    parameter int WIDTH = auth_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = &(a ~^ b);

endmodule

// File: rtl/param_auth_ctrl.sv
// Passcode authentication controller: stores a code, checks guesses one at a
// time and locks out for LOCK_CYCLES after MAX_TRIES consecutive failures.
module param_auth_ctrl
    import auth_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             set_valid,
    input  logic [WIDTH-1:0]                 set_code,
    input  logic                             guess_valid,
    input  logic [WIDTH-1:0]                 guess_code,
    input  logic                             relock,
    output logic                             guess_ready,
    output logic                             matched,
    output logic                             unmatched,
    output logic                             locked,
    output logic                             code_set,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam int TIM_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0] MAX_TRIES_C   = CNT_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [TIM_W-1:0] LOCK_CYCLES_C = TIM_W'(LOCK_CYCLES);
    localparam logic [TIM_W-1:0] TIM_ONE       = TIM_W'(1);

    auth_state_e        state_q, state_d;
    logic [WIDTH-1:0]   code_q, code_d;
    logic [WIDTH-1:0]   guess_q, guess_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic [TIM_W-1:0]   timer_q, timer_d;

    logic               guess_ready_q, guess_ready_d;
    logic               matched_q, matched_d;
    logic               unmatched_q, unmatched_d;
    logic               locked_q, locked_d;
    logic               code_set_q, code_set_d;
    logic [CNT_W-1:0]   tries_left_q, tries_left_d;

    logic               codes_equal;
    logic [CNT_W-1:0]   fail_inc;

    auth_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (guess_q),
        .b  (code_q),
        .eq (codes_equal)
    );

    // fail_q stays below MAX_TRIES outside LOCKED, so the increment cannot wrap.
    assign fail_inc = fail_q + CNT_ONE;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        code_d      = code_q;
        guess_d     = guess_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        matched_d   = 1'b0;
        unmatched_d = 1'b0;

        case (state_q)
            ST_UNSET: begin
                if (set_valid) begin
                    code_d  = set_code;
                    fail_d  = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (guess_valid) begin
                    guess_d = guess_code;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (codes_equal) begin
                    matched_d = 1'b1;
                    fail_d    = '0;
                    state_d   = ST_OPEN;
                end else begin
                    unmatched_d = 1'b1;
                    fail_d      = fail_inc;
                    if (fail_inc == MAX_TRIES_C) begin
                        timer_d = LOCK_CYCLES_C;
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_OPEN: begin
                if (set_valid) begin
                    code_d  = set_code;
                    state_d = ST_ARMED;
                end else if (relock) begin
                    state_d = ST_ARMED;
                end
            end
            ST_LOCKED: begin
                timer_d = timer_q - TIM_ONE;
                if (timer_q == TIM_ONE) begin
                    fail_d  = '0;
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_UNSET;
            end
        endcase

        // Status outputs are derived from the next state so they are registered
        // yet line up with the state they describe.
        guess_ready_d = (state_d == ST_ARMED);
        locked_d      = (state_d == ST_LOCKED);
        code_set_d    = (state_d != ST_UNSET);
        tries_left_d  = (state_d == ST_LOCKED) ? '0 : (MAX_TRIES_C - fail_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the passcode and guess registers are reset too; they are
            // plain flops, and a defined value keeps the comparator quiet.
            state_q       <= ST_UNSET;
            code_q        <= '0;
            guess_q       <= '0;
            fail_q        <= '0;
            timer_q       <= '0;
            guess_ready_q <= 1'b0;
            matched_q     <= 1'b0;
            unmatched_q   <= 1'b0;
            locked_q      <= 1'b0;
            code_set_q    <= 1'b0;
            tries_left_q  <= MAX_TRIES_C;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            guess_q       <= guess_d;
            fail_q        <= fail_d;
            timer_q       <= timer_d;
            guess_ready_q <= guess_ready_d;
            matched_q     <= matched_d;
            unmatched_q   <= unmatched_d;
            locked_q      <= locked_d;
            code_set_q    <= code_set_d;
            tries_left_q  <= tries_left_d;
        end
    end

    assign guess_ready = guess_ready_q;
    assign matched     = matched_q;
    assign unmatched   = unmatched_q;
    assign locked      = locked_q;
    assign code_set    = code_set_q;
    assign tries_left  = tries_left_q;

endmodule
